// File: rtl/config_chain_loader.sv
// config_chain_loader
//   Loads a CHAIN_LEN-bit configuration image into a daisy-chained DSP
//   configuration cell. The image arrives as WORD_W-bit words over a
//   valid/ready handshake. Each word is shifted into the chain head one bit
//   per enabled cycle, bit 0 first. While shifting, the bits leaving the
//   chain tail are captured into rb_data, so that after a full load rb_data
//   holds the previous chain contents.
//
//   State table:
//     IDLE  | waiting for start; no handshake, chain held
//     FETCH | word_ready high; waiting for the next image word
//     SHIFT | configuration_enable high; one bit per cycle into the chain
//     DONE  | one-cycle done pulse, then back to IDLE
//
// Ports:
//   clk, rst                     rise-edge clock, async active-high reset
//   start, abort                 load control
//   word_in, word_valid          image word stream
//   word_ready                   word accepted on this cycle
//   configuration_input/_enable  serial data and shift enable to the chain
//   configuration_output         serial data from the chain tail
//   busy, done, aborted          status (done/aborted are one-cycle pulses)
//   rb_data                      captured readback image
module config_chain_loader #(
  parameter int CHAIN_LEN = 16,
  parameter int WORD_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WORD_W-1:0]    word_in,
  input  logic                 word_valid,
  output logic                 word_ready,
  output logic                 configuration_input,
  output logic                 configuration_enable,
  input  logic                 configuration_output,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [CHAIN_LEN-1:0] rb_data
);

  localparam int NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - (NUM_WORDS - 1) * WORD_W;
  localparam int CW        = $clog2(CHAIN_LEN + 1);
  localparam int BW        = $clog2(WORD_W + 1);
  localparam int WCW       = $clog2(NUM_WORDS + 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [BW-1:0]         bits_q, bits_d;
  logic [WCW-1:0]        wcnt_q, wcnt_d;
  logic [WORD_W-1:0]     wbuf_q, wbuf_d;
  logic [CHAIN_LEN-1:0]  rb_q, rb_d;
  logic                  abort_take;

  logic word_ready_q, cfg_in_q, cfg_en_q, busy_q, done_q, aborted_q;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    bits_d     = bits_q;
    wcnt_d     = wcnt_q;
    wbuf_d     = wbuf_q;
    rb_d       = rb_q;
    abort_take = 1'b0;

    if (state_q != IDLE && abort) begin
      state_d    = IDLE;
      abort_take = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          rb_d    = '0;
          count_d = '0;
          wcnt_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (!abort && word_valid) begin
          wbuf_d  = word_in;
          // Only the final word can be short; padding bits are never shifted.
          bits_d  = (wcnt_q == WCW'(NUM_WORDS - 1)) ? BW'(LAST_BITS) : BW'(WORD_W);
          wcnt_d  = wcnt_q + 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // The chain sees enable high on this edge even when abort wins the
        // state transition, so the capture and bookkeeping still happen.
        // rb_data is cleared at start and each index is written once.
        rb_d    = rb_q | (CHAIN_LEN'(configuration_output) << count_q);
        wbuf_d  = wbuf_q >> 1;
        count_d = count_q + 1'b1;
        bits_d  = bits_q - 1'b1;
        if (!abort && bits_q == BW'(1)) begin
          state_d = (count_d == CW'(CHAIN_LEN)) ? DONE : FETCH;
        end
      end
      DONE: begin
        if (!abort) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      bits_q       <= '0;
      wcnt_q       <= '0;
      wbuf_q       <= '0;
      rb_q         <= '0;
      word_ready_q <= 1'b0;
      cfg_in_q     <= 1'b0;
      cfg_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      bits_q       <= bits_d;
      wcnt_q       <= wcnt_d;
      wbuf_q       <= wbuf_d;
      rb_q         <= rb_d;
      // Outputs are registered from the next state so they line up with it.
      word_ready_q <= (state_d == FETCH);
      cfg_en_q     <= (state_d == SHIFT);
      cfg_in_q     <= (state_d == SHIFT) ? wbuf_d[0] : 1'b0;
      busy_q       <= (state_d != IDLE);
      done_q       <= (state_d == DONE);
      aborted_q    <= abort_take;
    end
  end

  assign word_ready           = word_ready_q;
  assign configuration_input  = cfg_in_q;
  assign configuration_enable = cfg_en_q;
  assign busy                 = busy_q;
  assign done                 = done_q;
  assign aborted              = aborted_q;
  assign rb_data              = rb_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Bench for config_chain_loader: two instances (CHAIN_LEN=16 and 13) each
// driving a behavioural chain model. Expected completions are queued when a
// load is issued; monitors pop and compare on every done/aborted pulse.
module tb_config_chain_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       start = 1'b0, abort = 1'b0, word_valid = 1'b0, sel13 = 1'b0;
  logic [7:0] word_in = '0;

  logic        wr16, ci16, en16, co16, busy16, done16, ab16;
  logic [15:0] rb16, m16;
  logic        wr13, ci13, en13, co13, busy13, done13, ab13;
  logic [12:0] rb13, m13;

  logic        preset_req = 1'b0, clr_req = 1'b0;
  logic [15:0] preset16 = '0;
  logic [12:0] preset13 = '0;
  int          en_cnt16 = 0, en_cnt13 = 0, cyc = 0, start_cyc = 0;
  int          checks = 0, errors = 0;

  typedef struct {
    bit          ab;
    logic [15:0] rb;
    logic [15:0] m;
    int          en;
    int          lat;
  } exp_t;
  exp_t q16[$];
  exp_t q13[$];

  assign co16 = m16[0];
  assign co13 = m13[0];

  config_chain_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut16 (
    .clk(clk), .rst(rst), .start(start & ~sel13), .abort(abort & ~sel13),
    .word_in(word_in), .word_valid(word_valid & ~sel13), .word_ready(wr16),
    .configuration_input(ci16), .configuration_enable(en16),
    .configuration_output(co16), .busy(busy16), .done(done16),
    .aborted(ab16), .rb_data(rb16)
  );

  config_chain_loader #(.CHAIN_LEN(13), .WORD_W(8)) dut13 (
    .clk(clk), .rst(rst), .start(start & sel13), .abort(abort & sel13),
    .word_in(word_in), .word_valid(word_valid & sel13), .word_ready(wr13),
    .configuration_input(ci13), .configuration_enable(en13),
    .configuration_output(co13), .busy(busy13), .done(done13),
    .aborted(ab13), .rb_data(rb13)
  );

  // Chain models and enabled-cycle counters.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preset_req) begin
      m16 <= preset16;
      m13 <= preset13;
    end else begin
      if (en16) m16 <= {ci16, m16[15:1]};
      if (en13) m13 <= {ci13, m13[12:1]};
    end
    if (clr_req) begin
      en_cnt16 <= 0;
      en_cnt13 <= 0;
    end else begin
      if (en16) en_cnt16 <= en_cnt16 + 1;
      if (en13) en_cnt13 <= en_cnt13 + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (done16 || ab16)) begin
      if (q16.size() == 0) chk("unexpected_pulse16", 1, 0);
      else begin
        e = q16.pop_front();
        chk("kind16", 32'(ab16), 32'(e.ab));
        chk("rb16", 32'(rb16), 32'(e.rb));
        chk("m16", 32'(m16), 32'(e.m));
        chk("en_cnt16", en_cnt16, e.en);
        if (e.ab) chk("busy_after_abort16", 32'(busy16), 0);
        else      chk("latency16", cyc - start_cyc, e.lat);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (done13 || ab13)) begin
      if (q13.size() == 0) chk("unexpected_pulse13", 1, 0);
      else begin
        e = q13.pop_front();
        chk("kind13", 32'(ab13), 32'(e.ab));
        chk("rb13", 32'(rb13), 32'(e.rb));
        chk("m13", 32'(m13), 32'(e.m));
        chk("en_cnt13", en_cnt13, e.en);
        if (e.ab) chk("busy_after_abort13", 32'(busy13), 0);
        else      chk("latency13", cyc - start_cyc, e.lat);
      end
    end
  end

  task automatic push16(input bit ab, input logic [15:0] rb, input logic [15:0] m,
                        input int en, input int lat);
    exp_t e;
    e.ab = ab; e.rb = rb; e.m = m; e.en = en; e.lat = lat;
    q16.push_back(e);
  endtask

  task automatic push13(input logic [15:0] rb, input logic [15:0] m, input int en,
                        input int lat);
    exp_t e;
    e.ab = 1'b0; e.rb = rb; e.m = m; e.en = en; e.lat = lat;
    q13.push_back(e);
  endtask

  task automatic preset(input logic [15:0] v16, input logic [12:0] v13);
    @(negedge clk);
    preset16 = v16; preset13 = v13; preset_req = 1'b1;
    @(posedge clk); #1 preset_req = 1'b0;
  endtask

  task automatic do_start(input bit s13);
    @(negedge clk);
    sel13 = s13; clr_req = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clr_req = 1'b0; start_cyc = cyc;
  endtask

  task automatic send_word(input logic [7:0] w, input int stall);
    int n = 0;
    logic [15:0] ms;
    @(negedge clk);
    while (!(sel13 ? wr13 : wr16) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("ready_timeout", 0, 1);
    ms = m16;
    repeat (stall) begin
      @(negedge clk);
      chk("stall_enable", 32'(en16), 0);
      chk("stall_chain", 32'(m16), 32'(ms));
    end
    word_in = w; word_valid = 1'b1;
    @(posedge clk); #1 word_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q16.size() + q13.size()) != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("completion_timeout", 32'(n < 200), 1);
    @(negedge clk);
  endtask

  task automatic wait_shifts(input int k);
    int n = 0;
    while (en_cnt16 != k && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("shift_wait_timeout", 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_word_ready", 32'(wr16), 0);
    chk("rst_enable", 32'(en16), 0);
    chk("rst_cfg_in", 32'(ci16), 0);
    chk("rst_busy", 32'(busy16), 0);
    chk("rst_done", 32'(done16), 0);
    chk("rst_aborted", 32'(ab16), 0);
    chk("rst_rb", 32'(rb16), 0);
    rst = 1'b0;

    // Full load, word_valid ready immediately.
    preset(16'hA5C3, 13'h0);
    push16(0, 16'hA5C3, 16'h1234, 16, 18);
    do_start(0); send_word(8'h34, 0); send_word(8'h12, 0);
    wait_done();

    // Same load with a 5-cycle stall before the second word.
    preset(16'hA5C3, 13'h0);
    push16(0, 16'hA5C3, 16'h1234, 16, 23);
    do_start(0); send_word(8'h34, 0); send_word(8'h12, 5);
    wait_done();

    // Round trip of the readback; a start pulse mid-load is ignored.
    push16(0, 16'h1234, 16'hA5C3, 16, 18);
    do_start(0); send_word(8'hC3, 0);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    send_word(8'hA5, 0);
    wait_done();

    // Abort after 5 shifted bits of 8'hFF.
    preset(16'h0000, 13'h0);
    push16(1, 16'h0000, 16'hF800, 5, 0);
    do_start(0); send_word(8'hFF, 0);
    wait_shifts(4);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    chk("no_late_done", 32'(done16), 0);

    // Abort while idle has no effect.
    @(negedge clk) abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("idle_abort_pulse", 32'(ab16), 0);
    chk("idle_abort_busy", 32'(busy16), 0);

    // Asynchronous reset mid-shift.
    preset(16'hFFFF, 13'h0);
    do_start(0); send_word(8'h55, 0);
    wait_shifts(3);
    chk("pre_rst_rb_nonzero", 32'(rb16 != 16'h0), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_enable", 32'(en16), 0);
    chk("async_rst_busy", 32'(busy16), 0);
    chk("async_rst_rb", 32'(rb16), 0);
    @(negedge clk) rst = 1'b0;
    preset(16'hBEEF, 13'h0);
    push16(0, 16'hBEEF, 16'h1234, 16, 18);
    do_start(0); send_word(8'h34, 0); send_word(8'h12, 0);
    wait_done();

    // CHAIN_LEN=13: padding bits of the second word are never shifted.
    preset(16'h0, 13'h0ABC);
    push13(16'h0ABC, 16'h1FFF, 13, 15);
    do_start(1); send_word(8'hFF, 0); send_word(8'hFF, 0);
    wait_done();
    sel13 = 1'b0;

    chk("queue_empty", q16.size() + q13.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Drives the configuration-chain port (configuration_input / configuration_enable / configuration_output) of a daisy-chained DSP configuration cell, such as a mode manager.
- Accepts a CHAIN_LEN-bit configuration image as WORD_W-bit words over a valid/ready handshake and serializes it into the chain at one bit per enabled cycle.
- While shifting, it captures the bits leaving the chain tail. After a full load, rb_data therefore holds the previous chain contents, used for readback and verification.

Parameters:
- CHAIN_LEN, 16, number of configuration flops in the target chain (>=1).
- WORD_W, 8, width of each input image word (>=1).
- NUM_WORDS, ceil(CHAIN_LEN/WORD_W), derived (localparam); number of words per image.

Ports:
- clk  input  1  system clock; all flops rise-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a load; sampled only in IDLE.
- abort  input  1  cancel a load in progress; returns to IDLE.
- word_in  input  WORD_W  image word; bit 0 is shifted first.
- word_valid  input  1  word_in is valid.
- word_ready  output  1  loader accepts word_in this cycle.
- configuration_input  output  1  serial bit into the chain head.
- configuration_enable  output  1  chain shift enable.
- configuration_output  input  1  serial bit from the chain tail.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a load completes.
- aborted  output  1  one-cycle pulse when abort takes effect.
- rb_data  output  CHAIN_LEN  captured readback image.

Behaviour:
- Reset (asynchronous, takes effect without a clock edge):
  - state=IDLE.
  - All outputs 0, including rb_data, configuration_enable and configuration_input.
  - Bit counter and word buffer cleared.
- Stream order:
  - Stream bit s = word w, bit b, where s = w*WORD_W + b. Words are sent in order, bit 0 first.
  - Bit s is presented on the s-th enabled cycle.
  - Bits with s >= CHAIN_LEN (padding in the final word) are discarded and never shifted.
- All outputs come directly from flops; no combinational path from inputs to outputs.
- States:
  - IDLE: word_ready=0, configuration_enable=0. If start=1 and abort=0: clear rb_data, set count=0, go to FETCH.
  - FETCH: word_ready=1, configuration_enable=0. On word_valid: latch word_in into the buffer, set bits_left=min(WORD_W, CHAIN_LEN-count), go to SHIFT. Without word_valid, stay in FETCH; the chain holds.
  - SHIFT: configuration_enable=1, configuration_input=buf[0]. At each edge:
    - rb_data[count] <= configuration_output (the tail bit leaving on this same edge);
    - buf shifts right by 1; count++; bits_left--.
    - When bits_left reaches 0: go to DONE if count==CHAIN_LEN, else go to FETCH.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency with word_valid held high: done is high in cycle NUM_WORDS+CHAIN_LEN after the edge that accepts start (18 for the defaults).
- configuration_enable is high for exactly CHAIN_LEN cycles per completed load.
- Abort:
  - Honoured in any non-IDLE state; abort has priority over every other transition, including start, the DONE transition and word acceptance.
  - Next state is IDLE; configuration_enable=0 from that edge on; aborted pulses once; done is not asserted.
  - The chain keeps whatever bits were already shifted; rb_data keeps its partial capture.
- start while busy: ignored. abort while IDLE: no effect, no pulse.
- Counter width: $clog2(CHAIN_LEN+1). No wrap is possible, because count stops at CHAIN_LEN.

Test Plan:
- Bench chain model: m <= {configuration_input, m[CHAIN_LEN-1:1]} when enabled; configuration_output = m[0].
- Defaults, model preset m=16'hA5C3; start, then words 8'h34 and 8'h12 with word_valid held high -> done in cycle 18, configuration_enable high for exactly 16 cycles, m=16'h1234, rb_data=16'hA5C3.
- Same load, but word_valid low for 5 cycles before the second word -> configuration_enable low throughout the stall, m unchanged during the stall, done in cycle 23, same final values.
- Round trip: reload the rb_data from the first test (16'hA5C3) as words 8'hC3, 8'hA5 -> m=16'hA5C3, rb_data=16'h1234.
- Abort in SHIFT after 5 bits of 8'hFF with m=0 -> enable low from the next edge, aborted pulses once, no done, busy low, m=16'hF800.
- Assert rst asynchronously mid-SHIFT -> configuration_enable, busy and rb_data are 0 before the next clk edge; start after release runs a clean full load.
- CHAIN_LEN=13, words 8'hFF, 8'hFF -> configuration_enable high for exactly 13 cycles, m=13'h1FFF, done in cycle 15; padding bits 13-15 never shifted.
